insn_fetch: RTL

Instruction fetch unit: the producer end of the decoder's instruction interface. Holds the program counter, issues in-order read requests to instruction memory, buffers returned words with their PC in a small queue, and presents them to the decoder under valid/ready. Branch/jump resolution redirects it through a single-cycle redirect port that flushes the queue and discards in-flight responses.

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_checker.sv | 21 ++
 rtl/fetch_queue.sv | 90 +++++++++
 rtl/insn_fetch.sv | 170 +++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types and sizing helpers for the instruction fetch unit.
package fetch_pkg;

  localparam int DEF_INSN_WIDTH = 32;
  localparam int DEF_ADDR_WIDTH = 32;

  // Bytes per instruction word, i.e. the PC step between sequential fetches.
  function automatic int insn_bytes(input int insn_width);
    return insn_width / 8;
  endfunction

  // Width of a counter that must hold every value from 0 up to depth.
  function automatic int cnt_width(input int depth);
    return $clog2(depth + 1);
  endfunction

  // One buffered instruction together with the address it was fetched from.
  typedef struct packed {
    logic [DEF_INSN_WIDTH-1:0] insn;
    logic [DEF_ADDR_WIDTH-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/fetch_checker.sv
// Protocol and credit invariants of the fetch unit, kept out of the datapath.
module fetch_checker #(
  parameter int DEPTH = 4,
  parameter int CW    = 3
) (
  input logic          clk,
  input logic          reset_n,
  input logic          rsp_valid,
  input logic [CW-1:0] outstanding,
  input logic [CW-1:0] q_count
);

  // Memory may only answer requests it has accepted.
  a_rsp_has_request: assert property (@(posedge clk) disable iff (!reset_n)
    rsp_valid |-> (outstanding != '0));

  // In-flight plus buffered words never exceed the queue capacity.
  a_credit_bound: assert property (@(posedge clk) disable iff (!reset_n)
    (({1'b0, outstanding} + {1'b0, q_count}) <= (CW+1)'(DEPTH)));

endmodule

// File: rtl/fetch_queue.sv
// Small synchronous FIFO of fetched instructions. The head entry comes
// straight out of the storage flops, so there is no combinational path from
// push data to the head outputs. Flush empties the queue in one cycle.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter type entry_t = fetch_entry_t,
  parameter int  DEPTH   = 4
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        push_i,
  input  entry_t                      push_data_i,
  input  logic                        pop_i,
  input  logic                        flush_i,
  output entry_t                      head_o,
  output logic                        head_valid_o,
  output logic [cnt_width(DEPTH)-1:0] count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);

  entry_t          mem_q [DEPTH];
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            do_push;
  logic            do_pop;

  assign do_push = push_i & ~flush_i & (count_q != CW'(DEPTH));
  assign do_pop  = pop_i & (count_q != '0);

  // Pointer and occupancy next-state; flush wins over everything else.
  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        wr_ptr_d = wr_ptr_q + PW'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({do_push, do_pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so the head reads as zero out of reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push) begin
      mem_q[wr_ptr_q] <= push_data_i;
    end
  end

  assign head_o       = mem_q[rd_ptr_q];
  assign head_valid_o = (count_q != '0);
  assign count_o      = count_q;

endmodule

// File: rtl/insn_fetch.sv
// Instruction fetch unit: owns the fetch PC, issues in-order requests within
// the credit of the queue, tags returned words with their PC and handles
// redirects by flushing the queue and dropping responses still in flight.
module insn_fetch
  import fetch_pkg::*;
#(
  parameter int                    INSN_WIDTH  = 32,
  parameter int                    ADDR_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0,
  parameter int                    QUEUE_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  output logic                  imem_req_valid,
  input  logic                  imem_req_ready,
  output logic [ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                  imem_rsp_valid,
  input  logic [INSN_WIDTH-1:0] imem_rsp_data,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_pc,
  output logic                  insn_valid,
  input  logic                  insn_ready,
  output logic [INSN_WIDTH-1:0] insn,
  output logic [ADDR_WIDTH-1:0] insn_pc
);

  localparam int                    CW   = cnt_width(QUEUE_DEPTH);
  localparam logic [ADDR_WIDTH-1:0] STEP = ADDR_WIDTH'(insn_bytes(INSN_WIDTH));

  typedef struct packed {
    logic [INSN_WIDTH-1:0] insn;
    logic [ADDR_WIDTH-1:0] pc;
  } entry_t;

  logic                  req_valid_q, req_valid_d;
  logic [ADDR_WIDTH-1:0] req_addr_q, req_addr_d;
  logic [ADDR_WIDTH-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]         outstanding_q, outstanding_d;
  logic [CW-1:0]         discard_q, discard_d;

  logic                  accept;
  logic                  push;
  logic                  pop;
  logic [CW-1:0]         q_count;
  logic [CW-1:0]         q_count_next;
  logic [CW:0]           occ_next;
  logic                  q_valid;
  entry_t                q_head;
  entry_t                push_entry;

  assign accept = req_valid_q & imem_req_ready;
  assign pop    = q_valid & insn_ready;
  // A response is kept only when nothing is marked for discard and no
  // redirect is flushing the queue in this very cycle.
  assign push   = imem_rsp_valid & (discard_q == '0) & ~redirect_valid;

  assign push_entry.insn = imem_rsp_data;
  assign push_entry.pc   = rsp_pc_q;

  // In-flight count: +1 per accepted request, -1 per response (kept or not).
  always_comb begin
    outstanding_d = outstanding_q;
    case ({accept, imem_rsp_valid})
      2'b10:   outstanding_d = outstanding_q + CW'(1);
      2'b01:   outstanding_d = outstanding_q - CW'(1);
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Discard count: a redirect marks everything still in flight for dropping.
  always_comb begin
    discard_d = discard_q;
    if (redirect_valid) begin
      discard_d = outstanding_d;
    end else if (imem_rsp_valid && (discard_q != '0)) begin
      discard_d = discard_q - CW'(1);
    end else begin
      discard_d = discard_q;
    end
  end

  // Request address and response-tag PC; both jump to the redirect target.
  always_comb begin
    req_addr_d = req_addr_q;
    rsp_pc_d   = rsp_pc_q;
    if (redirect_valid) begin
      req_addr_d = redirect_pc;
      rsp_pc_d   = redirect_pc;
    end else begin
      if (accept) begin
        req_addr_d = req_addr_q + STEP;
      end else begin
        req_addr_d = req_addr_q;
      end
      if (push) begin
        rsp_pc_d = rsp_pc_q + STEP;
      end else begin
        rsp_pc_d = rsp_pc_q;
      end
    end
  end

  // Queue occupancy after this cycle, mirrored here so the credit can be
  // registered instead of decoded combinationally from the counters.
  always_comb begin
    q_count_next = q_count;
    if (redirect_valid) begin
      q_count_next = '0;
    end else begin
      case ({push, pop})
        2'b10:   q_count_next = q_count + CW'(1);
        2'b01:   q_count_next = q_count - CW'(1);
        default: q_count_next = q_count;
      endcase
    end
  end

  assign occ_next    = {1'b0, outstanding_d} + {1'b0, q_count_next};
  assign req_valid_d = (occ_next < (CW+1)'(QUEUE_DEPTH));

  // Fetch-side state registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      req_valid_q   <= 1'b0;
      req_addr_q    <= RESET_PC;
      rsp_pc_q      <= RESET_PC;
      outstanding_q <= '0;
      discard_q     <= '0;
    end else begin
      req_valid_q   <= req_valid_d;
      req_addr_q    <= req_addr_d;
      rsp_pc_q      <= rsp_pc_d;
      outstanding_q <= outstanding_d;
      discard_q     <= discard_d;
    end
  end

  fetch_queue #(
    .entry_t (entry_t),
    .DEPTH   (QUEUE_DEPTH)
  ) u_queue (
    .clk          (clk),
    .reset_n      (reset_n),
    .push_i       (push),
    .push_data_i  (push_entry),
    .pop_i        (pop),
    .flush_i      (redirect_valid),
    .head_o       (q_head),
    .head_valid_o (q_valid),
    .count_o      (q_count)
  );

  fetch_checker #(
    .DEPTH (QUEUE_DEPTH),
    .CW    (CW)
  ) u_checker (
    .clk         (clk),
    .reset_n     (reset_n),
    .rsp_valid   (imem_rsp_valid),
    .outstanding (outstanding_q),
    .q_count     (q_count)
  );

  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = req_addr_q;
  assign insn_valid     = q_valid;
  assign insn           = q_head.insn;
  assign insn_pc        = q_head.pc;

endmodule
